// File: rtl/cpu_pkg.sv
// Shared ISA constants for the simple RISC CPU: opcodes, sequencer phases and datapath widths.
package cpu_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] HLT = 3'd0;
  localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
  localparam logic [OPCODE_W-1:0] ADD = 3'd2;
  localparam logic [OPCODE_W-1:0] AND = 3'd3;
  localparam logic [OPCODE_W-1:0] XOR = 3'd4;
  localparam logic [OPCODE_W-1:0] LDA = 3'd5;
  localparam logic [OPCODE_W-1:0] STO = 3'd6;
  localparam logic [OPCODE_W-1:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: phase register, sticky halted flag and a
// combinational strobe decode of the registered phase, opcode and zero flag.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                ld_ac,
  output logic                wr,
  output logic                data_e,
  output logic                halt,
  output logic [2:0]          phase
);

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next phase and strobes; reset masks every output in the same cycle.
  always_comb begin
    phase_d  = phase_e'(3'(phase_q) + 3'd1);
    halted_d = halted_q;
    sel      = 1'b0;
    rd       = 1'b0;
    ld_ir    = 1'b0;
    inc_pc   = 1'b0;
    ld_pc    = 1'b0;
    ld_ac    = 1'b0;
    wr       = 1'b0;
    data_e   = 1'b0;
    halt     = 1'b0;
    phase    = 3'(phase_q);

    if (rst) begin
      phase = 3'd0;
    end else if (halted_q) begin
      // Halted parks the phase register at OP_ADDR until reset.
      halt    = 1'b1;
      phase_d = phase_q;
    end else begin
      unique case (phase_q)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          if (opcode == HLT) begin
            halt     = 1'b1;
            halted_d = 1'b1;
            phase_d  = OP_ADDR;
          end else begin
            inc_pc = 1'b1;
          end
        end
        OP_FETCH: rd = is_aluop(opcode);
        ALU_OP: begin
          rd     = is_aluop(opcode);
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = is_aluop(opcode);
          ld_ac  = is_aluop(opcode);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller with a small program-counter model driven by its strobes.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  logic [8:0] outs;
  logic [4:0] pc;
  logic [4:0] operand;
  logic       pc_preset;
  logic [4:0] pc_preset_val;

  int vectors;
  int miscompares;

  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
  assign outs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  always @(posedge clk) begin
    if (pc_preset)   pc <= pc_preset_val;
    else if (inc_pc) pc <= pc + 5'd1;
    else if (ld_pc)  pc <= operand;
  end

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); rst = 1'b1; #1;
      vectors++;
      if (outs !== 9'b0) begin
        miscompares++;
        $display("FAIL reset_outs c%0d: got %b want %b", c, outs, 9'b0);
      end
      vectors++;
      if (phase !== 3'd0) begin
        miscompares++;
        $display("FAIL reset_phase c%0d: got %0d want 0", c, phase);
      end
    end
    @(posedge clk); #1; rst = 1'b0; #1;
    vectors++;
    if (phase !== 3'd0 || halt !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: got phase %0d halt %b want phase 0 halt 0", phase, halt);
    end
  endtask

  task automatic test_add();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      opcode = (p < 3) ? JMP : ADD;  // pre-IR opcode must not matter
      zero = 1'b0;
      pc_preset = (p == 0);
      pc_preset_val = 5'd0;
      #1;
      vectors++;
      if (phase !== 3'(p) || outs !== exp[p]) begin
        miscompares++;
        $display("FAIL add p%0d: got phase %0d outs %b want phase %0d outs %b", p, phase, outs, p, exp[p]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (pc !== 5'd1) begin
      miscompares++;
      $display("FAIL add_pc: got %0d want 1", pc);
    end
  endtask

  task automatic test_skz();
    logic [8:0] exp [8];
    logic [4:0] want_pc;
    for (int z = 1; z >= 0; z--) begin
      exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
              9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
      if (z == 1) exp[6] = 9'b000100000;
      want_pc = (z == 1) ? 5'd5 : 5'd4;
      for (int p = 0; p < 8; p++) begin
        @(negedge clk);
        opcode = SKZ;
        zero = (p == 6) ? 1'(z) : ~1'(z);  // zero only counts in ALU_OP
        pc_preset = (p == 0);
        pc_preset_val = 5'd3;
        #1;
        vectors++;
        if (phase !== 3'(p) || outs !== exp[p]) begin
          miscompares++;
          $display("FAIL skz_z%0d p%0d: got phase %0d outs %b want phase %0d outs %b", z, p, phase, outs, p, exp[p]);
        end
      end
      @(posedge clk); #1;
      vectors++;
      if (pc !== want_pc) begin
        miscompares++;
        $display("FAIL skz_z%0d_pc: got %0d want %0d", z, pc, want_pc);
      end
    end
  endtask

  task automatic test_jmp();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b000000000, 9'b000010000, 9'b000000000};
    operand = 5'b10101;
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      opcode = JMP;
      zero = 1'b1;
      pc_preset = (p == 0);
      pc_preset_val = 5'd7;
      #1;
      vectors++;
      if (phase !== 3'(p) || outs !== exp[p]) begin
        miscompares++;
        $display("FAIL jmp p%0d: got phase %0d outs %b want phase %0d outs %b", p, phase, outs, p, exp[p]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (pc !== 5'b10101) begin
      miscompares++;
      $display("FAIL jmp_pc: got %b want 10101", pc);
    end
  endtask

  task automatic test_sto();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110};
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      opcode = STO;
      zero = 1'b0;
      pc_preset = (p == 0);
      pc_preset_val = 5'd9;
      #1;
      vectors++;
      if (phase !== 3'(p) || outs !== exp[p]) begin
        miscompares++;
        $display("FAIL sto p%0d: got phase %0d outs %b want phase %0d outs %b", p, phase, outs, p, exp[p]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (pc !== 5'd10) begin
      miscompares++;
      $display("FAIL sto_pc: got %0d want 10", pc);
    end
  endtask

  task automatic test_halt();
    logic [8:0] exp [5];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000, 9'b000000001};
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      opcode = HLT;
      zero = 1'b1;
      pc_preset = (p == 0);
      pc_preset_val = 5'd12;
      #1;
      vectors++;
      if (phase !== 3'(p) || outs !== exp[p]) begin
        miscompares++;
        $display("FAIL hlt p%0d: got phase %0d outs %b want phase %0d outs %b", p, phase, outs, p, exp[p]);
      end
    end
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      opcode = 3'(c);  // opcode churn must not wake a halted CPU
      zero = ~zero;
      #1;
      vectors++;
      if (phase !== 3'd4 || outs !== 9'b000000001) begin
        miscompares++;
        $display("FAIL halted c%0d: got phase %0d outs %b want phase 4 outs 000000001", c, phase, outs);
      end
    end
    vectors++;
    if (pc !== 5'd12) begin
      miscompares++;
      $display("FAIL hlt_pc: got %0d want 12", pc);
    end
    @(negedge clk); rst = 1'b1; #1;
    vectors++;
    if (outs !== 9'b0 || phase !== 3'd0) begin
      miscompares++;
      $display("FAIL hlt_rst: got phase %0d outs %b want phase 0 outs 000000000", phase, outs);
    end
    @(posedge clk); #1; rst = 1'b0; #1;
    vectors++;
    if (phase !== 3'd0 || halt !== 1'b0) begin
      miscompares++;
      $display("FAIL hlt_unhalt: got phase %0d halt %b want phase 0 halt 0", phase, halt);
    end
    test_add();
  endtask

  task automatic test_reset_mid();
    operand = 5'b10101;
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      opcode = JMP;
      pc_preset = (p == 0);
      pc_preset_val = 5'd2;
      #1;
      vectors++;
      if (phase !== 3'(p)) begin
        miscompares++;
        $display("FAIL mid_phase p%0d: got %0d want %0d", p, phase, p);
      end
    end
    @(negedge clk); rst = 1'b1; #1;
    vectors++;
    if (outs !== 9'b0 || phase !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_rst: got phase %0d outs %b want phase 0 outs 000000000", phase, outs);
    end
    @(posedge clk); #1; rst = 1'b0; #1;
    vectors++;
    if (phase !== 3'd0 || pc !== 5'd3) begin
      miscompares++;
      $display("FAIL mid_after: got phase %0d pc %0d want phase 0 pc 3", phase, pc);
    end
    @(negedge clk); #1;
    vectors++;
    if (outs !== 9'b100000000) begin
      miscompares++;
      $display("FAIL mid_addr: got %b want 100000000", outs);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    opcode = ADD;
    zero = 1'b0;
    operand = 5'd0;
    pc_preset = 1'b1;
    pc_preset_val = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pc_preset = 1'b0;
    repeat (3) @(negedge clk);  // leave the sequencer mid-instruction
    test_reset();
    test_add();
    test_skz();
    test_jmp();
    test_sto();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Eight-phase instruction sequencer for the simple RISC CPU. It steps one instruction through fetch, decode and execute, and drives the control strobes for the program counter, instruction register, accumulator, memory and address mux. It consumes the opcode from the instruction register and the accumulator zero flag, and it is the only source of `ld_pc`/`inc_pc` for `program_counter`.

## Interface
- No parameters. Widths are fixed by the ISA (opcode 3 bits; address 5 bits in datapath).
- `clk` in 1: single system clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 3: instruction-register opcode field; must be stable from phase IDLE through STORE.
- `zero` in 1: accumulator == 0.
- `sel` out 1: address mux select; 1 = PC, 0 = IR operand.
- `rd` out 1: memory read enable.
- `ld_ir` out 1: instruction register load.
- `inc_pc` out 1: program counter increment.
- `ld_pc` out 1: program counter load from IR operand.
- `ld_ac` out 1: accumulator load.
- `wr` out 1: memory write strobe.
- `data_e` out 1: accumulator drives the data bus.
- `halt` out 1: CPU halted (sticky).
- `phase` out 3: current phase, for debug and bench.

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD, AND, XOR or LDA.
- Phases advance 0→7→0 unconditionally, except for HLT. Outputs are a combinational decode of the registered phase, opcode and zero.
- Phase outputs (any output not listed is 0):
  - 0 INST_ADDR: sel.
  - 1 INST_FETCH: sel, rd.
  - 2 INST_LOAD: sel, rd, ld_ir.
  - 3 IDLE: sel, rd, ld_ir.
  - 4 OP_ADDR: inc_pc if opcode≠HLT. If opcode=HLT: halt=1, inc_pc=0, and next state is HALTED.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; wr=STO; data_e=STO.
- HALTED is a ninth state, held until `rst`. In HALTED, halt=1, all other strobes are 0 and `phase` reads 4.
- `inc_pc` and `ld_pc` are never asserted in the same cycle.
- `wr` is only ever asserted while `data_e`=1.

## Timing
- Reset:
  - While `rst`=1, every output is forced to 0 combinationally, including `halt`; `phase` reads 0.
  - On the edge where `rst`=1: state becomes INST_ADDR and the halted flag clears.
  - Reset mid-instruction aborts the instruction with no further strobes. The first post-reset cycle is INST_ADDR.
- Each instruction takes exactly 8 cycles. There are no wait states and no bubbles between instructions.
- PC effects:
  - PC increments once per instruction, on the edge closing OP_ADDR.
  - SKZ with zero=1 adds a second increment at ALU_OP, skipping the next instruction.
  - JMP loads the PC at the ALU_OP edge. The PC value after OP_ADDR is overwritten.
- `zero` is sampled only in ALU_OP. Changes to `zero` in other phases have no effect.
- Opcode changes outside phases 3-7 have no effect. `ld_ir` is asserted in phases 2-3, and the new opcode is valid from phase 4.
- HLT: `halt` rises in OP_ADDR (phase 4) and stays high every cycle afterwards until `rst`. The PC does not advance.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants HLT..JMP;
  - phase encodings INST_ADDR..STORE;
  - `ADDR_W`=5, `OPCODE_W`=3.
- `program_counter` and the other datapath blocks import the same package.
- No sub-module. The design is a 3-bit phase register, a halted flag and one decode block.

## Test plan
- Reset: hold `rst` 2 cycles from an arbitrary state. All outputs are 0 during reset; `phase`=0 on the first cycle after; `halt`=0.
- ADD (opcode=2), zero=0: over 8 cycles, `rd` is high in phases 1,2,3,5,6,7; `ld_ir` in 2-3; `inc_pc` only in phase 4; `ld_ac` only in phase 7; `wr`=0 throughout. A paired `program_counter` goes 0→1.
- SKZ (opcode=1): with zero=1, `inc_pc` is high in phases 4 and 6 and the PC goes 3→5. With zero=0, only phase 4 increments and the PC goes 3→4.
- JMP (opcode=7), IR operand=5'b10101: `ld_pc` is high only in phase 6 and `inc_pc` is low there. The PC reads 10101 at the start of the next INST_ADDR.
- STO (opcode=6): `data_e` is high in phases 6-7, `wr` only in phase 7, and `rd` stays 0 in phases 5-7.
- HLT (opcode=0): `halt` rises in phase 4 and stays high for 20 or more cycles; `inc_pc`, `rd` and `wr` stay 0. Then assert `rst`, and an ADD executes normally. Also assert `rst` in phase 6 of a JMP: `ld_pc` is never seen, and the next phase is 0.
